keccak_perm_ctrl: RTL and testbench
===================================

// Module: keccak_perm_ctrl
// PURPOSE
//  Sequences the single-round Keccak-f[1600] datapath inside the Keccak accelerator of keccak_x_heep_top.
//  Issues NUM_ROUNDS round requests with round index, and strobes the state-register write-back after each round.
//  Arbitrates state-register write access between host (bus) and datapath.
//  Reports completion (done pulse, sticky irq), watchdog errors and a completed-permutation count.
// PARAMETERS
//  NUM_ROUNDS   24   rounds per permutation (>=1)
//  TIMEOUT_CYC  64   max WAIT cycles per round before error (>=1)
//  CNT_W        16   width of completed-permutation counter
// PORTS
//  clk_i        in   1      clock
//  rst_i        in   1      synchronous reset, active-high
//  start_i      in   1      start request; accepted only in IDLE
//  abort_i      in   1      abort current permutation
//  busy_o       out  1      high in ISSUE/WAIT/FINISH
//  done_o       out  1      1-cycle pulse in FINISH
//  irq_o        out  1      sticky completion interrupt
//  irq_clr_i    in   1      clears irq_o
//  err_o        out  1      sticky watchdog error
//  host_req_i   in   1      host wants to write state register
//  host_gnt_o   out  1      host write granted (combinational)
//  dp_start_o   out  1      1-cycle round request to datapath
//  dp_round_o   out  $clog2(NUM_ROUNDS)  round index (round-constant select)
//  dp_done_i    in   1      datapath round result valid (pulse)
//  state_we_o   out  1      latch datapath result into state register
//  perm_cnt_o   out  CNT_W  completed permutations, wraps
// BEHAVIOUR
//  Reset: IDLE; round_cnt, wd_cnt, perm_cnt_o = 0; every output 0.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | FINISH) -> IDLE.
//  IDLE:
//   - host_gnt_o = host_req_i; busy_o = 0.
//   - start_i=1 -> ISSUE; round_cnt = 0; err_o cleared.
//   - start_i and host_req_i together: write granted this cycle, start also accepted.
//  ISSUE:
//   - dp_start_o = 1; dp_round_o = round_cnt; wd_cnt = 0.
//   - -> WAIT.
//  WAIT:
//   - wd_cnt increments each cycle without dp_done_i.
//   - dp_done_i=1 -> state_we_o = 1 (combinational, same cycle).
//     - round_cnt == NUM_ROUNDS-1 -> FINISH.
//     - else round_cnt++ -> ISSUE.
//   - wd_cnt reaches TIMEOUT_CYC without dp_done_i -> err_o = 1, -> IDLE; no done, no irq.
//  FINISH:
//   - done_o = 1; irq_o set; perm_cnt_o++ (wraps to 0 at max).
//   - -> IDLE.
//  dp_round_o holds round_cnt in all states (0 in IDLE).
//  host_gnt_o = 0 in every non-IDLE state, regardless of host_req_i.
//  Latency, 1-cycle datapath (dp_done_i the cycle after dp_start_o):
//   - start sampled at edge 0; round k ISSUE in cycle 2k+1, WAIT in cycle 2k+2.
//   - done_o in cycle 2*NUM_ROUNDS+1 (49 at default).
//   - busy_o high cycles 1..49.
//  abort_i in any non-IDLE state:
//   - -> IDLE next cycle; round_cnt = 0.
//   - state_we_o, done_o, irq set and perm_cnt increment suppressed that cycle, even with dp_done_i.
//   - abort_i in IDLE has no effect.
//  Ignored inputs: start_i while busy; dp_done_i outside WAIT.
//  irq_o: irq_clr_i clears it; set in FINISH wins over a simultaneous clear.
//  Synchronous reset mid-operation: all outputs 0 the next cycle; no done pulse.
// TESTING
//  1. Nominal: start, dp_done_i 1 cycle after each dp_start_o -> 24 dp_start_o with dp_round_o 0..23; 24 state_we_o; done_o at cycle 49; irq_o=1; perm_cnt_o=1.
//  2. Arbitration: host_req_i held from cycle 5 of a run -> host_gnt_o=0 until IDLE (cycle 50), then 1; host_req_i in IDLE -> gnt same cycle.
//  3. Abort in WAIT of round 10 with dp_done_i same cycle -> no state_we_o, IDLE next, no done/irq; restart -> full 24 rounds from dp_round_o=0.
//  4. Watchdog, TIMEOUT_CYC=16, datapath silent -> err_o=1 after 16 WAIT cycles, IDLE, irq_o=0; next start clears err_o.
//  5. irq_clr_i in FINISH cycle -> irq_o stays 1; start_i pulsed mid-run -> ignored; perm_cnt_o at 0xFFFF +1 run -> 0x0000.
//  6. rst_i asserted in round 7 -> next cycle busy_o, dp_start_o, irq_o, perm_cnt_o = 0; dp_done_i afterwards ignored.

Source files
------------

// File: rtl/keccak_perm_ctrl.sv
// Round sequencer for the single-round Keccak-f[1600] datapath: issues rounds, strobes
// state write-back, arbitrates host writes, and reports done/irq/watchdog/permutation count.
module keccak_perm_ctrl #(
    parameter int unsigned NUM_ROUNDS  = 24,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned RW   = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             irq_o,
    input  logic             irq_clr_i,
    output logic             err_o,
    input  logic             host_req_i,
    output logic             host_gnt_o,
    output logic             dp_start_o,
    output logic [RW-1:0]    dp_round_o,
    input  logic             dp_done_i,
    output logic             state_we_o,
    output logic [CNT_W-1:0] perm_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     round_cnt_q, round_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  perm_cnt_q, perm_cnt_d;

    logic              aborting;
    logic              finishing;
    logic              timing_out;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            round_cnt_q <= '0;
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
            irq_q       <= 1'b0;
            perm_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
            irq_q       <= irq_d;
            perm_cnt_q  <= perm_cnt_d;
        end
    end

    // Abort outranks every completion event raised in the same cycle.
    assign aborting   = abort_i && (state_q != S_IDLE);
    assign finishing  = (state_q == S_FINISH) && !aborting;
    assign timing_out = (state_q == S_WAIT) && !dp_done_i && !aborting &&
                        (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
        perm_cnt_d  = perm_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done_i) begin
                    if (round_cnt_q == RW'(NUM_ROUNDS - 1)) begin
                        state_d = S_FINISH;
                    end else begin
                        round_cnt_d = round_cnt_q + RW'(1);
                        state_d     = S_ISSUE;
                    end
                end else if (timing_out) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (aborting) begin
            state_d = S_IDLE;
        end
        if (finishing) begin
            perm_cnt_d = perm_cnt_q + CNT_W'(1);
        end
        // Set wins over a simultaneous clear.
        irq_d = finishing || (irq_q && !irq_clr_i);
        // Round index reads 0 whenever the sequencer rests in IDLE.
        if (state_d == S_IDLE) begin
            round_cnt_d = '0;
        end
    end

    always_comb begin
        busy_o     = (state_q != S_IDLE);
        host_gnt_o = (state_q == S_IDLE) && host_req_i;
        dp_start_o = (state_q == S_ISSUE);
        state_we_o = (state_q == S_WAIT) && dp_done_i && !aborting;
        done_o     = finishing;
        dp_round_o = round_cnt_q;
        err_o      = err_q;
        irq_o      = irq_q;
        perm_cnt_o = perm_cnt_q;
    end

endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Self-checking bench for keccak_perm_ctrl: a cycle schedule derived from per-round
// datapath latencies predicts every output; a second small instance exercises counter wrap.
module tb_keccak_perm_ctrl;

    localparam int NR   = 24;
    localparam int TO   = 16;
    localparam int RW_A = 5;
    localparam int NR_B = 2;

    logic        clk = 1'b0;
    logic        rst, start, abort, irq_clr, host_req, dp_done;
    logic        busy, done, irq, err, host_gnt, dp_start, state_we;
    logic [RW_A-1:0] dp_round;
    logic [15:0] perm_cnt;

    logic        b_start, b_dp_done;
    logic        b_busy, b_done, b_irq, b_err, b_gnt, b_dp_start, b_we;
    logic [0:0]  b_dp_round;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    // Model state carried between scenarios.
    bit          exp_irq = 1'b0;
    bit          exp_err = 1'b0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    keccak_perm_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .busy_o(busy), .done_o(done), .irq_o(irq), .irq_clr_i(irq_clr),
        .err_o(err), .host_req_i(host_req), .host_gnt_o(host_gnt),
        .dp_start_o(dp_start), .dp_round_o(dp_round), .dp_done_i(dp_done),
        .state_we_o(state_we), .perm_cnt_o(perm_cnt)
    );

    keccak_perm_ctrl #(.NUM_ROUNDS(NR_B), .TIMEOUT_CYC(4), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .abort_i(1'b0),
        .busy_o(b_busy), .done_o(b_done), .irq_o(b_irq), .irq_clr_i(1'b0),
        .err_o(b_err), .host_req_i(1'b0), .host_gnt_o(b_gnt),
        .dp_start_o(b_dp_start), .dp_round_o(b_dp_round), .dp_done_i(b_dp_done),
        .state_we_o(b_we), .perm_cnt_o(b_cnt)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; irq_clr = 0; host_req = 0; dp_done = 0;
        b_start = 0; b_dp_done = 0;
    endtask

    // One permutation from IDLE. Round k waits lat_k extra WAIT cycles before dp_done.
    // host_mode: 0 none, 1 random, 2 held at cycle 0 and from cycle 5. clr_mode: 0 none, 1 random, 2 in FINISH.
    task automatic run_perm(input string name, input int lat_lo, input int lat_hi,
                            input int host_mode, input int clr_mode,
                            input bit start_glitch, input bit abort_idle);
        int issue_c[NR];
        int done_c[NR];
        int fin, clr_c, lat;
        bit in_issue, in_done, busy_e, irq_e, err_e, irq0;
        logic [6:0] exp_v, obs_v;
        logic [RW_A-1:0] exp_r;
        logic [15:0] exp_pc;
        irq0 = exp_irq;
        issue_c[0] = 1;
        for (int k = 0; k < NR; k++) begin
            lat = int'($urandom_range(lat_hi, lat_lo));
            done_c[k] = issue_c[k] + 1 + lat;
            if (k < NR - 1) issue_c[k+1] = done_c[k] + 1;
        end
        fin = done_c[NR-1] + 1;
        clr_c = (clr_mode == 1) ? int'($urandom_range(fin, 1)) : (clr_mode == 2) ? fin : -1;
        for (int c = 0; c <= fin + 1; c++) begin
            in_issue = 0; in_done = 0; exp_r = '0;
            for (int k = 0; k < NR; k++) begin
                if (c == issue_c[k]) in_issue = 1;
                if (c == done_c[k]) in_done = 1;
                if (c >= issue_c[k] && c <= done_c[k]) exp_r = RW_A'(k);
            end
            if (c == fin) exp_r = RW_A'(NR - 1);
            start    = (c == 0) || (start_glitch && c <= fin && $urandom_range(1, 0) == 1);
            abort    = abort_idle && (c == 0);
            irq_clr  = (c == clr_c);
            host_req = (host_mode == 1) ? ($urandom_range(1, 0) == 1) :
                       (host_mode == 2) ? (c == 0 || c >= 5) : 1'b0;
            dp_done  = in_done || ((in_issue || c == 0 || c >= fin) && $urandom_range(1, 0) == 1);
            busy_e   = (c >= 1) && (c <= fin);
            if (c > fin) irq_e = 1;
            else if (clr_c >= 0 && c > clr_c) irq_e = 0;
            else irq_e = irq0;
            err_e  = (c == 0) ? exp_err : 1'b0;
            exp_pc = (c > fin) ? exp_cnt + 16'd1 : exp_cnt;
            exp_v  = {busy_e, c == fin, in_issue, in_done, host_req && !busy_e, irq_e, err_e};
            @(negedge clk);
            obs_v = {busy, done, dp_start, state_we, host_gnt, irq, err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s c=%0d {busy,done,dp_start,we,gnt,irq,err} got %b want %b", name, c, obs_v, exp_v);
            end
            checks++;
            if (dp_round !== exp_r) begin
                errors++;
                $display("FAIL %s c=%0d dp_round got %0d want %0d", name, c, dp_round, exp_r);
            end
            checks++;
            if (perm_cnt !== exp_pc) begin
                errors++;
                $display("FAIL %s c=%0d perm_cnt got %0d want %0d", name, c, perm_cnt, exp_pc);
            end
            next_cycle();
        end
        idle_inputs();
        exp_irq = 1; exp_err = 0; exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({busy, done, irq, err, host_gnt, dp_start, state_we, dp_round, perm_cnt} !== '0) begin
            errors++;
            $display("FAIL reset outputs got busy=%b done=%b irq=%b err=%b gnt=%b st=%b we=%b rnd=%0d cnt=%0d want all 0",
                     busy, done, irq, err, host_gnt, dp_start, state_we, dp_round, perm_cnt);
        end
        rst = 0;
        next_cycle();
    endtask

    task automatic test_nominal();
        run_perm("nominal", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random_latency();
        for (int i = 0; i < 3; i++)
            run_perm("random", 0, 6, 1, 1, 1, $urandom_range(1, 0) == 1);
    endtask

    task automatic test_arbitration();
        host_req = 1;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b1) begin
            errors++;
            $display("FAIL arb_idle gnt got %b want 1", host_gnt);
        end
        next_cycle();
        host_req = 0;
        @(negedge clk);
        checks++;
        if (host_gnt !== 1'b0) begin
            errors++;
            $display("FAIL arb_idle_off gnt got %b want 0", host_gnt);
        end
        next_cycle();
        run_perm("arb_held", 0, 0, 2, 0, 0, 0);
    endtask

    task automatic test_abort();
        irq_clr = 1;
        next_cycle();
        irq_clr = 0;
        exp_irq = 0;
        for (int c = 0; c <= 25; c++) begin
            start   = (c == 0);
            abort   = (c == 22);
            dp_done = (c >= 2) && (c % 2 == 0);
            @(negedge clk);
            if (c == 21) begin
                checks++;
                if ({dp_start, dp_round} !== {1'b1, RW_A'(10)}) begin
                    errors++;
                    $display("FAIL abort_pre dp_start/round got %b/%0d want 1/10", dp_start, dp_round);
                end
            end
            if (c == 22) begin
                checks++;
                if ({busy, state_we, done} !== 3'b100) begin
                    errors++;
                    $display("FAIL abort_cycle busy/we/done got %b%b%b want 100", busy, state_we, done);
                end
            end
            if (c >= 23) begin
                checks++;
                if ({busy, state_we, done, dp_start, irq, dp_round, perm_cnt} !== {5'b0, exp_irq, RW_A'(0), exp_cnt}) begin
                    errors++;
                    $display("FAIL abort_after c=%0d busy=%b we=%b done=%b st=%b irq=%b rnd=%0d cnt=%0d want idle irq=%b cnt=%0d",
                             c, busy, state_we, done, dp_start, irq, dp_round, perm_cnt, exp_irq, exp_cnt);
                end
            end
            next_cycle();
        end
        idle_inputs();
        run_perm("abort_restart", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_watchdog();
        irq_clr = 1;
        next_cycle();
        irq_clr = 0;
        exp_irq = 0;
        for (int c = 0; c <= 19; c++) begin
            start   = (c == 0);
            dp_done = (c == 19);
            @(negedge clk);
            checks++;
            if ({busy, err, done, state_we, irq} !== {c >= 1 && c <= 17, c >= 18, 3'b000}) begin
                errors++;
                $display("FAIL watchdog c=%0d busy/err/done/we/irq got %b%b%b%b%b want %b%b000",
                         c, busy, err, done, state_we, irq, c >= 1 && c <= 17, c >= 18);
            end
            next_cycle();
        end
        idle_inputs();
        exp_err = 1;
        run_perm("after_watchdog", 0, 3, 0, 0, 0, 0);
        run_perm("watchdog_edge", TO - 1, TO - 1, 0, 0, 0, 0);
    endtask

    task automatic test_irq_clr();
        run_perm("irq_clr_fin", 0, 2, 0, 2, 1, 0);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 17; c++) begin
            start   = (c == 0);
            rst     = (c == 15);
            dp_done = (c >= 2 && c % 2 == 0) || c >= 16;
            @(negedge clk);
            if (c == 15) begin
                checks++;
                if ({dp_start, dp_round} !== {1'b1, RW_A'(7)}) begin
                    errors++;
                    $display("FAIL rst_mid_pre dp_start/round got %b/%0d want 1/7", dp_start, dp_round);
                end
            end
            if (c >= 16) begin
                checks++;
                if ({busy, dp_start, irq, err, done, state_we, dp_round, perm_cnt} !== '0) begin
                    errors++;
                    $display("FAIL rst_mid c=%0d busy=%b st=%b irq=%b err=%b done=%b we=%b rnd=%0d cnt=%0d want all 0",
                             c, busy, dp_start, irq, err, done, state_we, dp_round, perm_cnt);
                end
            end
            next_cycle();
        end
        idle_inputs();
        rst = 0;
        exp_irq = 0; exp_err = 0; exp_cnt = '0;
        run_perm("after_rst_mid", 0, 4, 1, 0, 0, 0);
    endtask

    // Two-round instance: rounds issue in cycles 1 and 3, results in 2 and 4, done in 5.
    task automatic test_wrap();
        for (int r = 0; r <= 16; r++) begin
            for (int c = 0; c <= 5; c++) begin
                b_start   = (c == 0);
                b_dp_done = (c == 2) || (c == 4);
                @(negedge clk);
                if (c == 5) begin
                    checks++;
                    if (b_done !== 1'b1) begin
                        errors++;
                        $display("FAIL wrap_done run=%0d got %b want 1", r, b_done);
                    end
                end
                next_cycle();
            end
            idle_inputs();
            @(negedge clk);
            checks++;
            if (b_cnt !== 4'((r + 1) % 16)) begin
                errors++;
                $display("FAIL wrap_cnt run=%0d got %0d want %0d", r, b_cnt, (r + 1) % 16);
            end
            next_cycle();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        next_cycle();
        test_reset();
        test_nominal();
        test_random_latency();
        test_arbitration();
        test_abort();
        test_watchdog();
        test_irq_clr();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
